// File: rtl/spi_master_seq.sv
// spi_master_seq
// Transaction sequencer in front of the SPI transmit shifter. It latches one
// configured transaction (command, address, dummy, data phases) and walks the
// shifter through it phase by phase, pulling data-phase words from the TX FIFO.
// It also owns chip-select generation and flags end of transfer.
//
// Ports
//   clk, rstn                 clock, async active-low reset
//   start                     transaction request (ignored while busy)
//   cfg_*                     transaction description, latched on start
//   fifo_data/valid/ready     TX FIFO pop interface
//   tx_*                      shifter controls; tx_data_ready/tx_done come back
//   spi_csn                   active-low chip selects
//   busy, eot                 status: in progress, end-of-transfer pulse
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | waiting for start, chip selects high
// CS_ON     | chip select low, choose first non-empty phase
// LOAD      | one-cycle bit-count load into the shifter
// SEND      | first word of the phase offered to the shifter
// WAIT_DONE | shifter running; data phase keeps feeding FIFO words
// EOT       | chip selects high, end-of-transfer pulse

module spi_master_seq #(
    parameter int NUM_CS = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [1:0]        cfg_cs,
    input  logic [31:0]       cfg_cmd,
    input  logic [5:0]        cfg_cmd_len,
    input  logic [31:0]       cfg_addr,
    input  logic [5:0]        cfg_addr_len,
    input  logic [15:0]       cfg_dummy,
    input  logic [15:0]       cfg_data_len,
    input  logic              cfg_quad,
    input  logic [31:0]       fifo_data,
    input  logic              fifo_valid,
    output logic              fifo_ready,
    output logic              tx_en,
    output logic              tx_en_quad,
    output logic [15:0]       tx_counter,
    output logic              tx_counter_upd,
    output logic [31:0]       tx_data,
    output logic              tx_data_valid,
    input  logic              tx_data_ready,
    input  logic              tx_done,
    output logic [NUM_CS-1:0] spi_csn,
    output logic              busy,
    output logic              eot
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CS_ON, ST_LOAD, ST_SEND, ST_WAIT_DONE, ST_EOT
    } state_t;

    typedef enum logic [1:0] {
        PH_CMD, PH_ADDR, PH_DUMMY, PH_DATA
    } phase_t;

    state_t            state_q, state_d;
    phase_t            phase_q, phase_d;
    logic [1:0]        cs_q, cs_d;
    logic [31:0]       cmd_q, cmd_d, addr_q, addr_d;
    logic [5:0]        cmd_len_q, cmd_len_d, addr_len_q, addr_len_d;
    logic [15:0]       dummy_q, dummy_d, data_len_q, data_len_d;
    logic              quad_q, quad_d;
    logic [11:0]       words_left_q, words_left_d;

    logic              tx_en_q, tx_en_d;
    logic              tx_en_quad_q, tx_en_quad_d;
    logic [15:0]       tx_counter_q, tx_counter_d;
    logic              tx_counter_upd_q, tx_counter_upd_d;
    logic [31:0]       tx_data_q, tx_data_d;
    logic              tx_data_valid_q, tx_data_valid_d;
    logic [NUM_CS-1:0] spi_csn_q, spi_csn_d;
    logic              busy_q, busy_d;
    logic              eot_q, eot_d;

    logic [3:0]        has_phase, cand;
    logic [2:0]        lo;
    logic              found;
    phase_t            next_ph;
    logic [11:0]       data_words;
    logic [5:0]        cmd_sh, addr_sh;
    logic              fwd, hs;

    // Next non-empty phase: from CMD when leaving CS_ON, otherwise strictly
    // after the current phase. lo == 4 masks everything off.
    always_comb begin
        has_phase = {data_len_q != 16'd0, dummy_q != 16'd0,
                     addr_len_q != 6'd0, cmd_len_q != 6'd0};
        lo        = (state_q == ST_WAIT_DONE) ? ({1'b0, phase_q} + 3'd1) : 3'd0;
        cand      = has_phase & ~((4'd1 << lo) - 4'd1);
        found     = cand != 4'd0;
        next_ph   = PH_DATA;
        if (cand[0])      next_ph = PH_CMD;
        else if (cand[1]) next_ph = PH_ADDR;
        else if (cand[2]) next_ph = PH_DUMMY;
    end

    assign data_words = {1'b0, data_len_q[15:5]} + {11'd0, |data_len_q[4:0]};
    // 6-bit subtraction: a 32-bit field shifts by 0, not by 32.
    assign cmd_sh     = 6'd32 - cmd_len_q;
    assign addr_sh    = 6'd32 - addr_len_q;

    // Data phase bypasses the output flops so the FIFO handshake reaches the
    // shifter in the same cycle, including its mid-phase word reload.
    assign fwd = (phase_q == PH_DATA) &&
                 ((state_q == ST_SEND) ||
                  (state_q == ST_WAIT_DONE && words_left_q != 12'd0));
    assign tx_data_valid = fwd ? fifo_valid : tx_data_valid_q;
    assign tx_data       = fwd ? fifo_data  : tx_data_q;
    assign fifo_ready    = fwd & tx_data_ready;
    assign hs            = tx_data_valid & tx_data_ready;

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        cs_d         = cs_q;
        cmd_d        = cmd_q;
        cmd_len_d    = cmd_len_q;
        addr_d       = addr_q;
        addr_len_d   = addr_len_q;
        dummy_d      = dummy_q;
        data_len_d   = data_len_q;
        quad_d       = quad_q;
        words_left_d = words_left_q;

        if (fwd && hs) words_left_d = words_left_q - 12'd1;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cs_d       = cfg_cs;
                    cmd_d      = cfg_cmd;
                    cmd_len_d  = cfg_cmd_len;
                    addr_d     = cfg_addr;
                    addr_len_d = cfg_addr_len;
                    dummy_d    = cfg_dummy;
                    data_len_d = cfg_data_len;
                    quad_d     = cfg_quad;
                    state_d    = ST_CS_ON;
                end
            end
            ST_CS_ON: begin
                if (found) begin
                    state_d = ST_LOAD;
                    phase_d = next_ph;
                end else begin
                    state_d = ST_EOT;
                end
            end
            ST_LOAD: state_d = ST_SEND;
            ST_SEND: if (hs) state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (tx_done) begin
                    if (found) begin
                        state_d = ST_LOAD;
                        phase_d = next_ph;
                    end else begin
                        state_d = ST_EOT;
                    end
                end
            end
            ST_EOT:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_LOAD && phase_d == PH_DATA) words_left_d = data_words;

        // Outputs are registered from the state being entered.
        tx_en_d          = (state_d == ST_SEND) || (state_d == ST_WAIT_DONE);
        tx_counter_upd_d = (state_d == ST_LOAD);
        tx_data_valid_d  = (state_d == ST_SEND) && (phase_d != PH_DATA);
        busy_d           = (state_d != ST_IDLE);
        eot_d            = (state_d == ST_EOT);
        spi_csn_d        = (state_d == ST_IDLE || state_d == ST_EOT) ?
                           {NUM_CS{1'b1}} : ~(NUM_CS'(1) << cs_d);

        tx_counter_d = tx_counter_q;
        tx_en_quad_d = tx_en_quad_q;
        if (state_d == ST_LOAD) begin
            tx_en_quad_d = (phase_d == PH_CMD) ? 1'b0 : quad_d;
            case (phase_d)
                PH_CMD:   tx_counter_d = {10'd0, cmd_len_d};
                PH_ADDR:  tx_counter_d = {10'd0, addr_len_d};
                PH_DUMMY: tx_counter_d = quad_d ? {dummy_d[13:0], 2'b00} : dummy_d;
                default:  tx_counter_d = data_len_d;
            endcase
        end

        tx_data_d = tx_data_q;
        if (state_d == ST_SEND) begin
            case (phase_d)
                PH_CMD:  tx_data_d = cmd_q << cmd_sh;
                PH_ADDR: tx_data_d = addr_q << addr_sh;
                default: tx_data_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q          <= ST_IDLE;
            phase_q          <= PH_CMD;
            cs_q             <= 2'd0;
            cmd_q            <= 32'd0;
            cmd_len_q        <= 6'd0;
            addr_q           <= 32'd0;
            addr_len_q       <= 6'd0;
            dummy_q          <= 16'd0;
            data_len_q       <= 16'd0;
            quad_q           <= 1'b0;
            words_left_q     <= 12'd0;
            tx_en_q          <= 1'b0;
            tx_en_quad_q     <= 1'b0;
            tx_counter_q     <= 16'd0;
            tx_counter_upd_q <= 1'b0;
            tx_data_q        <= 32'd0;
            tx_data_valid_q  <= 1'b0;
            spi_csn_q        <= {NUM_CS{1'b1}};
            busy_q           <= 1'b0;
            eot_q            <= 1'b0;
        end else begin
            state_q          <= state_d;
            phase_q          <= phase_d;
            cs_q             <= cs_d;
            cmd_q            <= cmd_d;
            cmd_len_q        <= cmd_len_d;
            addr_q           <= addr_d;
            addr_len_q       <= addr_len_d;
            dummy_q          <= dummy_d;
            data_len_q       <= data_len_d;
            quad_q           <= quad_d;
            words_left_q     <= words_left_d;
            tx_en_q          <= tx_en_d;
            tx_en_quad_q     <= tx_en_quad_d;
            tx_counter_q     <= tx_counter_d;
            tx_counter_upd_q <= tx_counter_upd_d;
            tx_data_q        <= tx_data_d;
            tx_data_valid_q  <= tx_data_valid_d;
            spi_csn_q        <= spi_csn_d;
            busy_q           <= busy_d;
            eot_q            <= eot_d;
        end
    end

    assign tx_en          = tx_en_q;
    assign tx_en_quad     = tx_en_quad_q;
    assign tx_counter     = tx_counter_q;
    assign tx_counter_upd = tx_counter_upd_q;
    assign spi_csn        = spi_csn_q;
    assign busy           = busy_q;
    assign eot            = eot_q;

endmodule

// File: tb/tb_spi_master_seq.sv
// Bench for spi_master_seq: a small shifter/FIFO model answers the DUT, the
// directed tests push hand-computed expectations into queues, and a monitor
// pops and compares them as the DUT presents loads, words and eot pulses.
module tb_spi_master_seq;
    localparam int NUM_CS = 4;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start = 1'b0;
    logic [1:0]        cfg_cs = '0;
    logic [31:0]       cfg_cmd = '0;
    logic [5:0]        cfg_cmd_len = '0;
    logic [31:0]       cfg_addr = '0;
    logic [5:0]        cfg_addr_len = '0;
    logic [15:0]       cfg_dummy = '0;
    logic [15:0]       cfg_data_len = '0;
    logic              cfg_quad = 1'b0;
    logic [31:0]       fifo_data = '0;
    logic              fifo_valid = 1'b0;
    logic              fifo_ready;
    logic              tx_en, tx_en_quad, tx_counter_upd, tx_data_valid;
    logic [15:0]       tx_counter;
    logic [31:0]       tx_data;
    logic              tx_data_ready = 1'b0;
    logic              tx_done = 1'b0;
    logic [NUM_CS-1:0] spi_csn;
    logic              busy, eot;

    always #5 clk = ~clk;

    spi_master_seq #(.NUM_CS(NUM_CS)) dut (
        .clk(clk), .rstn(rstn), .start(start),
        .cfg_cs(cfg_cs), .cfg_cmd(cfg_cmd), .cfg_cmd_len(cfg_cmd_len),
        .cfg_addr(cfg_addr), .cfg_addr_len(cfg_addr_len), .cfg_dummy(cfg_dummy),
        .cfg_data_len(cfg_data_len), .cfg_quad(cfg_quad),
        .fifo_data(fifo_data), .fifo_valid(fifo_valid), .fifo_ready(fifo_ready),
        .tx_en(tx_en), .tx_en_quad(tx_en_quad), .tx_counter(tx_counter),
        .tx_counter_upd(tx_counter_upd), .tx_data(tx_data),
        .tx_data_valid(tx_data_valid), .tx_data_ready(tx_data_ready),
        .tx_done(tx_done), .spi_csn(spi_csn), .busy(busy), .eot(eot)
    );

    typedef struct packed {
        logic [15:0] cnt;
        logic        quad;
    } upd_t;

    upd_t              exp_upd[$];
    logic [31:0]       exp_word[$];
    bit                exp_eot[$];
    logic [31:0]       fifo_q[$];

    int                checks = 0;
    int                errors = 0;
    int                cyc = 0;
    int                done_cyc = -10;
    logic [NUM_CS-1:0] exp_csn = '1;
    int                ready_delay = 1;
    bit                done_en = 1'b1;
    int                pops = 0;
    int                n;
    int                pops_before;

    upd_t              m_e;
    logic [31:0]       m_w;
    bit                m_f;

    bit                s_v, s_hs, s_pop, s_counting;
    int                s_vcnt = 0;
    int                s_dcnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Shifter and FIFO model: samples at negedge, drives just after posedge.
    initial begin
        forever begin
            @(negedge clk);
            s_v   = tx_en && tx_data_valid && !tx_data_ready;
            s_hs  = tx_en && tx_data_valid && tx_data_ready;
            s_pop = fifo_ready && fifo_valid;
            @(posedge clk);
            #1;
            tx_done = 1'b0;
            if (!rstn) begin
                s_vcnt        = 0;
                s_counting    = 1'b0;
                tx_data_ready = 1'b0;
            end else begin
                if (s_pop) begin
                    void'(fifo_q.pop_front());
                    pops++;
                end
                if (s_v) begin
                    s_vcnt++;
                    if (s_vcnt >= ready_delay) tx_data_ready = 1'b1;
                end
                if (s_counting) begin
                    if (s_dcnt == 0) begin
                        if (done_en) begin
                            tx_done       = 1'b1;
                            tx_data_ready = 1'b0;
                            s_vcnt        = 0;
                            s_counting    = 1'b0;
                        end
                    end else begin
                        s_dcnt--;
                    end
                end else if (s_hs) begin
                    s_counting = 1'b1;
                    s_dcnt     = 6;
                end
            end
            fifo_valid = fifo_q.size() > 0;
            fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        cyc++;
        if (rstn) begin
            if (busy && !eot) check("csn_active", 64'(spi_csn), 64'(exp_csn));
            if (tx_counter_upd) begin
                checks++;
                if (exp_upd.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_upd: actual counter %0d required no load", tx_counter);
                end else begin
                    m_e = exp_upd.pop_front();
                    check("upd_counter", 64'(tx_counter), 64'(m_e.cnt));
                    check("upd_quad", 64'(tx_en_quad), 64'(m_e.quad));
                    check("upd_tx_en", 64'(tx_en), 64'd0);
                end
            end
            if (tx_en && tx_data_valid && tx_data_ready) begin
                checks++;
                if (exp_word.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: actual %0h required no word", tx_data);
                end else begin
                    m_w = exp_word.pop_front();
                    check("word", 64'(tx_data), 64'(m_w));
                end
            end
            if (tx_done) begin
                done_cyc = cyc;
                check("valid_at_done", 64'(tx_data_valid), 64'd0);
                check("en_at_done", 64'(tx_en), 64'd1);
            end
            if (eot) begin
                checks++;
                if (exp_eot.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_eot: actual eot 1 required 0");
                end else begin
                    m_f = exp_eot.pop_front();
                    check("eot_csn", 64'(spi_csn), 64'({NUM_CS{1'b1}}));
                    check("eot_tx_en", 64'(tx_en), 64'd0);
                    if (m_f) check("eot_latency", 64'(cyc), 64'(done_cyc + 1));
                end
            end
        end
    end

    task automatic push_upd(input logic [15:0] cnt, input logic quad);
        upd_t e;
        e.cnt  = cnt;
        e.quad = quad;
        exp_upd.push_back(e);
    endtask

    task automatic set_cfg(input logic [1:0] cs, input logic [31:0] cmd, input logic [5:0] cmd_len,
                           input logic [31:0] addr, input logic [5:0] addr_len,
                           input logic [15:0] dummy, input logic [15:0] data_len, input logic quad);
        cfg_cs       = cs;
        cfg_cmd      = cmd;
        cfg_cmd_len  = cmd_len;
        cfg_addr     = addr;
        cfg_addr_len = addr_len;
        cfg_dummy    = dummy;
        cfg_data_len = data_len;
        cfg_quad     = quad;
        exp_csn      = ~(NUM_CS'(1) << cs);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_eot(input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (eot !== 1'b1 && k < 400);
        checks++;
        if (eot !== 1'b1) begin
            errors++;
            $display("FAIL %s_eot_timeout: actual eot %0b required 1", name, eot);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string name);
        check({name, "_csn"}, 64'(spi_csn), 64'({NUM_CS{1'b1}}));
        check({name, "_counter"}, 64'(tx_counter), 64'd0);
        check({name, "_data"}, 64'(tx_data), 64'd0);
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_eot"}, 64'(eot), 64'd0);
        check({name, "_tx_en"}, 64'(tx_en), 64'd0);
        check({name, "_upd"}, 64'(tx_counter_upd), 64'd0);
        check({name, "_valid"}, 64'(tx_data_valid), 64'd0);
        check({name, "_fifo_ready"}, 64'(fifo_ready), 64'd0);
        check({name, "_quad"}, 64'(tx_en_quad), 64'd0);
    endtask

    initial begin
        #12;
        check_reset("reset");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Command only, with start/load/enable latencies.
        set_cfg(2'd0, 32'h9F, 6'd8, 32'h0, 6'd0, 16'd0, 16'd0, 1'b0);
        push_upd(16'd8, 1'b0);
        exp_word.push_back(32'h9F00_0000);
        exp_eot.push_back(1'b1);
        pulse_start();
        @(negedge clk);
        check("start_to_cs", 64'(spi_csn), 64'(4'b1110));
        check("cs_on_no_upd", 64'(tx_counter_upd), 64'd0);
        @(negedge clk);
        check("cs_to_upd", 64'(tx_counter_upd), 64'd1);
        @(negedge clk);
        check("upd_to_en", 64'(tx_en), 64'd1);
        wait_eot("cmd_only");

        // Quad read: 8 single, 24, 32, then 40 bits of data (two FIFO words).
        fifo_q.push_back(32'hCAFE_0001);
        fifo_q.push_back(32'hBEEF_0002);
        set_cfg(2'd1, 32'h6B, 6'd8, 32'h0012_3456, 6'd24, 16'd8, 16'd40, 1'b1);
        push_upd(16'd8, 1'b0);
        push_upd(16'd24, 1'b1);
        push_upd(16'd32, 1'b1);
        push_upd(16'd40, 1'b1);
        exp_word.push_back(32'h6B00_0000);
        exp_word.push_back(32'h1234_5600);
        exp_word.push_back(32'h0000_0000);
        exp_word.push_back(32'hCAFE_0001);
        exp_word.push_back(32'hBEEF_0002);
        exp_eot.push_back(1'b1);
        pops_before = pops;
        pulse_start();
        wait_eot("quad_read");
        check("quad_pops", 64'(pops - pops_before), 64'd2);

        // Boundaries: 32-bit command, 1-bit address, single dummy; cfg
        // scrambled while busy must not matter. Slow shifter ready.
        ready_delay = 3;
        set_cfg(2'd3, 32'h0123_4567, 6'd32, 32'h1, 6'd1, 16'd5, 16'd0, 1'b0);
        push_upd(16'd32, 1'b0);
        push_upd(16'd1, 1'b0);
        push_upd(16'd5, 1'b0);
        exp_word.push_back(32'h0123_4567);
        exp_word.push_back(32'h8000_0000);
        exp_word.push_back(32'h0000_0000);
        exp_eot.push_back(1'b1);
        pulse_start();
        cfg_cmd      = 32'hFFFF_FFFF;
        cfg_cmd_len  = 6'd3;
        cfg_addr_len = 6'd0;
        cfg_dummy    = 16'd77;
        cfg_quad     = 1'b1;
        cfg_cs       = 2'd0;
        wait_eot("boundary");
        ready_delay = 1;

        // Multi-word data phase: 96 bits, three FIFO words.
        fifo_q.push_back(32'hA5A5_0001);
        fifo_q.push_back(32'h5A5A_0002);
        fifo_q.push_back(32'hDEAD_BEEF);
        set_cfg(2'd2, 32'h0, 6'd0, 32'h0, 6'd0, 16'd0, 16'd96, 1'b0);
        push_upd(16'd96, 1'b0);
        exp_word.push_back(32'hA5A5_0001);
        exp_word.push_back(32'h5A5A_0002);
        exp_word.push_back(32'hDEAD_BEEF);
        exp_eot.push_back(1'b1);
        pops_before = pops;
        pulse_start();
        wait_eot("multi_word");
        check("multi_pops", 64'(pops - pops_before), 64'd3);
        check("multi_fifo_empty", 64'(fifo_q.size()), 64'd0);

        // All lengths zero: one cycle of CS low, then eot, no loads.
        set_cfg(2'd1, 32'h0, 6'd0, 32'h0, 6'd0, 16'd0, 16'd0, 1'b0);
        exp_eot.push_back(1'b0);
        pulse_start();
        @(negedge clk);
        check("zero_cs_low", 64'(spi_csn), 64'(4'b1101));
        @(negedge clk);
        check("zero_eot", 64'(eot), 64'd1);
        check("zero_cs_high", 64'(spi_csn), 64'(4'b1111));
        @(negedge clk);
        check("zero_idle", 64'(busy), 64'd0);
        @(posedge clk);
        #1;

        // Back-to-back: start during eot is ignored, next start runs.
        set_cfg(2'd1, 32'hA5, 6'd8, 32'h0, 6'd0, 16'd0, 16'd0, 1'b0);
        push_upd(16'd8, 1'b0);
        exp_word.push_back(32'hA500_0000);
        exp_eot.push_back(1'b1);
        pulse_start();
        n = 0;
        while (eot !== 1'b1 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("b2b_eot_seen", 64'(eot), 64'd1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_start_ignored", 64'(busy), 64'd0);
        check("b2b_csn_high", 64'(spi_csn), 64'(4'b1111));
        set_cfg(2'd2, 32'h3C, 6'd8, 32'hAB, 6'd8, 16'd0, 16'd0, 1'b1);
        push_upd(16'd8, 1'b0);
        push_upd(16'd8, 1'b1);
        exp_word.push_back(32'h3C00_0000);
        exp_word.push_back(32'hAB00_0000);
        exp_eot.push_back(1'b1);
        pulse_start();
        wait_eot("b2b_second");

        // Reset while waiting for tx_done.
        done_en = 1'b0;
        set_cfg(2'd0, 32'h77, 6'd8, 32'h0, 6'd0, 16'd0, 16'd0, 1'b0);
        push_upd(16'd8, 1'b0);
        exp_word.push_back(32'h7700_0000);
        pulse_start();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(busy && tx_en && !tx_data_valid) && n < 50);
        check("reach_wait_done", 64'(busy && tx_en && !tx_data_valid), 64'd1);
        repeat (2) @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check_reset("mid_reset");
        repeat (2) @(posedge clk);
        #1;
        rstn    = 1'b1;
        done_en = 1'b1;
        @(negedge clk);
        check("after_reset_busy", 64'(busy), 64'd0);
        repeat (3) @(posedge clk);
        #1;

        check("left_upd", 64'(exp_upd.size()), 64'd0);
        check("left_word", 64'(exp_word.size()), 64'd0);
        check("left_eot", 64'(exp_eot.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
